// File: rtl/uart_rx_ext_if.sv
// AXI-Stream style character output bundle for uart_rx_ext.
interface uart_rx_ext_if #(
  parameter int DATA_WIDTH = 9
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_rx_ext.sv
// UART receiver with runtime-configurable framing, break detection and AXI-Stream output.
// Optional output FIFO enabled by defining UART_RX_FIFO_EN; otherwise a single overwrite register.
module uart_rx_ext #(
  parameter int DATA_WIDTH = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rxd,
  input  logic [15:0]        prescale,
  input  logic [3:0]         data_bits,
  input  logic [1:0]         parity_mode,
  input  logic               stop_bits,
  uart_rx_ext_if.master      m_axis,
  output logic               busy,
  output logic               overrun_error,
  output logic               frame_error,
  output logic               parity_error,
  output logic               break_detect
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  localparam logic [3:0] LP_DW = 4'(DATA_WIDTH);

  logic                  r_rxd_s1, r_rxd_s2;
  logic [2:0]            r_state;
  logic [18:0]           r_cnt;
  logic [15:0]           r_pre;
  logic [3:0]            r_bits;
  logic [1:0]            r_pmode;
  logic                  r_stop2;
  logic [DATA_WIDTH-1:0] r_data;
  logic [3:0]            r_idx;
  logic                  r_s0, r_s1;
  logic                  r_pbit, r_perr, r_ferr, r_stop_hi, r_sidx;
  logic                  r_fe_p, r_pe_p, r_bk_p, r_ovr_p;

  logic                  w_rxd;
  logic [15:0]           w_pre_in;
  logic [3:0]            w_bits_in;
  logic [18:0]           w_half_in;
  logic [18:0]           w_full;
  logic                  w_tick, w_maj, w_par_en;
  logic                  w_last_stop, w_zero, w_fe;
  logic                  w_brk, w_fe_p, w_pe_p, w_deliver;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_rxd     = r_rxd_s2;
  assign w_pre_in  = (prescale == 16'd0) ? 16'd1 : prescale;
  assign w_bits_in = (data_bits < 4'd5 || data_bits > LP_DW) ? LP_DW : data_bits;
  assign w_half_in = {1'b0, w_pre_in, 2'b00} - 19'd1;
  assign w_full    = {r_pre, 3'b000} - 19'd1;
  assign w_tick    = (r_cnt == 19'd0);
  assign w_maj     = (r_s0 & r_s1) | (r_s0 & w_rxd) | (r_s1 & w_rxd);
  assign w_par_en  = (r_pmode == 2'b01) || (r_pmode == 2'b10);
  // Bits are shifted in from the top, so short characters need re-alignment to the LSB.
  assign w_word    = r_data >> (LP_DW - r_bits);

  assign w_last_stop = (r_state == S_STOP) && w_tick && (!r_stop2 || r_sidx);
  assign w_fe        = r_ferr | ~w_maj;
  assign w_zero      = (r_data == '0) && !(w_par_en && r_pbit) && !r_stop_hi && !w_maj;
  assign w_brk       = w_last_stop & w_zero;
  assign w_fe_p      = w_last_stop & ~w_zero & w_fe;
  assign w_pe_p      = w_last_stop & ~w_zero & ~w_fe & r_perr;
  assign w_deliver   = w_last_stop & ~w_zero & ~w_fe & ~r_perr;

  assign busy          = (r_state != S_IDLE);
  assign frame_error   = r_fe_p;
  assign parity_error  = r_pe_p;
  assign break_detect  = r_bk_p;
  assign overrun_error = r_ovr_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxd_s1  <= 1'b1;
      r_rxd_s2  <= 1'b1;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pre     <= 16'd1;
      r_bits    <= LP_DW;
      r_pmode   <= 2'b00;
      r_stop2   <= 1'b0;
      r_data    <= '0;
      r_idx     <= '0;
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
      r_pbit    <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_stop_hi <= 1'b0;
      r_sidx    <= 1'b0;
      r_fe_p    <= 1'b0;
      r_pe_p    <= 1'b0;
      r_bk_p    <= 1'b0;
    end else begin
      r_rxd_s1 <= rxd;
      r_rxd_s2 <= r_rxd_s1;
      r_fe_p   <= w_fe_p;
      r_pe_p   <= w_pe_p;
      r_bk_p   <= w_brk;
      if (r_state != S_IDLE && r_state != S_BREAK) begin
        if (r_cnt == 19'd2) r_s0 <= w_rxd;
        if (r_cnt == 19'd1) r_s1 <= w_rxd;
        if (!w_tick) r_cnt <= r_cnt - 19'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (!w_rxd) begin
            r_state   <= S_START;
            r_cnt     <= w_half_in;
            r_pre     <= w_pre_in;
            r_bits    <= w_bits_in;
            r_pmode   <= parity_mode;
            r_stop2   <= stop_bits;
            r_data    <= '0;
            r_idx     <= '0;
            r_pbit    <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_stop_hi <= 1'b0;
            r_sidx    <= 1'b0;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (w_maj) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
              r_cnt   <= w_full;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_data <= {w_maj, r_data[DATA_WIDTH-1:1]};
            r_idx  <= r_idx + 4'd1;
            r_cnt  <= w_full;
            if (r_idx == r_bits - 4'd1) r_state <= w_par_en ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_pbit  <= w_maj;
            r_perr  <= (^r_data) ^ w_maj ^ r_pmode[1];
            r_cnt   <= w_full;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (!w_last_stop) begin
              r_ferr    <= r_ferr | ~w_maj;
              r_stop_hi <= r_stop_hi | w_maj;
              r_sidx    <= 1'b1;
              r_cnt     <= w_full;
            end else begin
              r_state <= w_brk ? S_BREAK : S_IDLE;
            end
          end
        end
        S_BREAK: begin
          if (w_rxd) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wptr, r_rptr;
  logic                  w_empty, w_full_f, w_pop, w_push;

  assign w_empty  = (r_wptr == r_rptr);
  assign w_full_f = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop    = ~w_empty & m_axis.tready;
  assign w_push   = w_deliver & (~w_full_f | w_pop);

  assign m_axis.tvalid = ~w_empty;
  assign m_axis.tdata  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_ovr_p <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_ovr_p <= w_deliver & w_full_f & ~w_pop;
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= w_word;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end
`else
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;

  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tdata  = r_tdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_ovr_p  <= 1'b0;
    end else begin
      r_ovr_p <= 1'b0;
      if (w_deliver) begin
        r_tdata  <= w_word;
        r_tvalid <= 1'b1;
        r_ovr_p  <= r_tvalid & ~m_axis.tready;
      end else if (r_tvalid && m_axis.tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: framing table plus break, glitch, overrun and reset sequences.
module tb_uart_rx_ext;
  localparam int DW = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic [15:0] prescale = 16'd1;
  logic [3:0]  data_bits = 4'd8;
  logic [1:0]  parity_mode = 2'b00;
  logic        stop_bits = 1'b0;
  logic        busy, ovr, fe, pe, bk;

  uart_rx_ext_if #(.DATA_WIDTH(DW)) m_axis();

  uart_rx_ext #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .prescale(prescale), .data_bits(data_bits),
    .parity_mode(parity_mode), .stop_bits(stop_bits), .m_axis(m_axis), .busy(busy),
    .overrun_error(ovr), .frame_error(fe), .parity_error(pe), .break_detect(bk)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_xfer = 0, n_pe = 0, n_fe = 0, n_bk = 0, n_ovr = 0;
  logic [DW-1:0] rx_q[$];
  logic prev_vld = 1'b0;
  int   vld_age = 0;
  logic busy_after = 1'b1;

  always @(negedge clk) begin
    if (m_axis.tvalid && m_axis.tready) begin
      n_xfer++;
      rx_q.push_back(m_axis.tdata);
    end
    if (pe)  n_pe++;
    if (fe)  n_fe++;
    if (bk)  n_bk++;
    if (ovr) n_ovr++;
    if (vld_age == 1) begin
      busy_after = busy;
      vld_age = 0;
    end
    if (m_axis.tvalid && !prev_vld) vld_age = 1;
    prev_vld = m_axis.tvalid;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic bit_time(input logic v, input int cyc);
    rxd = v;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] d, input int n, input bit haspar, input bit pb,
                      input int nstop, input bit s1, input bit s2, input int cyc);
    bit_time(1'b0, cyc);
    for (int i = 0; i < n; i++) bit_time(d[i], cyc);
    if (haspar) bit_time(pb, cyc);
    bit_time(s1, cyc);
    if (nstop == 2) bit_time(s2, cyc);
    rxd = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(nm, busy, 0);
    repeat (16) @(negedge clk);
  endtask

  typedef struct {
    logic [15:0]   pre;
    logic [3:0]    dbits;
    logic [1:0]    pmode;
    logic          sbits;
    int            nsend;
    logic [DW-1:0] d;
    bit            haspar;
    bit            pb;
    bit            s1;
    bit            s2;
    int            exp_n;
    logic [DW-1:0] exp_d;
    int            exp_pe;
    int            exp_fe;
    int            exp_bk;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int b_x, b_pe, b_fe, b_bk, b_ovr, cyc;
    logic [DW-1:0] got;

    //          pre    dbits  pm     sb    n  data     hp pb s1 s2  n  exp      pe fe bk
    vecs[0]  = '{16'd1, 4'd8,  2'b00, 1'b0, 8, 9'h055, 0, 0, 1, 1, 1, 9'h055, 0, 0, 0};
    vecs[1]  = '{16'd1, 4'd7,  2'b01, 1'b0, 7, 9'h041, 1, 0, 1, 1, 1, 9'h041, 0, 0, 0};
    vecs[2]  = '{16'd1, 4'd7,  2'b01, 1'b0, 7, 9'h041, 1, 1, 1, 1, 0, 9'h000, 1, 0, 0};
    vecs[3]  = '{16'd1, 4'd8,  2'b00, 1'b1, 8, 9'h0A5, 0, 0, 1, 0, 0, 9'h000, 0, 1, 0};
    vecs[4]  = '{16'd1, 4'd8,  2'b00, 1'b1, 8, 9'h03C, 0, 0, 1, 1, 1, 9'h03C, 0, 0, 0};
    vecs[5]  = '{16'd1, 4'd8,  2'b10, 1'b0, 8, 9'h000, 1, 1, 1, 1, 1, 9'h000, 0, 0, 0};
    vecs[6]  = '{16'd1, 4'd9,  2'b00, 1'b0, 9, 9'h1FF, 0, 0, 1, 1, 1, 9'h1FF, 0, 0, 0};
    vecs[7]  = '{16'd1, 4'd5,  2'b00, 1'b0, 5, 9'h015, 0, 0, 1, 1, 1, 9'h015, 0, 0, 0};
    vecs[8]  = '{16'd1, 4'd15, 2'b00, 1'b0, 9, 9'h123, 0, 0, 1, 1, 1, 9'h123, 0, 0, 0};
    vecs[9]  = '{16'd1, 4'd8,  2'b01, 1'b0, 8, 9'h001, 1, 0, 0, 1, 0, 9'h000, 0, 1, 0};
    vecs[10] = '{16'd1, 4'd8,  2'b11, 1'b0, 8, 9'h081, 0, 0, 1, 1, 1, 9'h081, 0, 0, 0};
    vecs[11] = '{16'd2, 4'd8,  2'b00, 1'b0, 8, 9'h0C3, 0, 0, 1, 1, 1, 9'h0C3, 0, 0, 0};
    vecs[12] = '{16'd0, 4'd6,  2'b10, 1'b0, 6, 9'h02A, 1, 0, 1, 1, 1, 9'h02A, 0, 0, 0};
    vecs[13] = '{16'd1, 4'd8,  2'b00, 1'b0, 8, 9'h000, 0, 0, 0, 1, 0, 9'h000, 0, 0, 1};
    vecs[14] = '{16'd1, 4'd4,  2'b00, 1'b0, 9, 9'h0F0, 0, 0, 1, 1, 1, 9'h0F0, 0, 0, 0};

    m_axis.tready = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_tvalid", m_axis.tvalid, 0);
    check("reset_tdata", m_axis.tdata, 0);
    check("reset_pulses", {ovr, fe, pe, bk}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 15; v++) begin
      prescale    = vecs[v].pre;
      data_bits   = vecs[v].dbits;
      parity_mode = vecs[v].pmode;
      stop_bits   = vecs[v].sbits;
      cyc = (vecs[v].pre == 16'd0) ? 8 : 8 * int'(vecs[v].pre);
      b_x = n_xfer; b_pe = n_pe; b_fe = n_fe; b_bk = n_bk; b_ovr = n_ovr;
      send(vecs[v].d, vecs[v].nsend, vecs[v].haspar, vecs[v].pb,
           vecs[v].sbits ? 2 : 1, vecs[v].s1, vecs[v].s2, cyc);
      wait_idle($sformatf("v%0d_idle", v));
      check($sformatf("v%0d_xfers", v), n_xfer - b_x, vecs[v].exp_n);
      if (vecs[v].exp_n > 0) begin
        got = (rx_q.size() > 0) ? rx_q[0] : 'x;
        check($sformatf("v%0d_tdata", v), got, vecs[v].exp_d);
      end
      rx_q.delete();
      check($sformatf("v%0d_parity_err", v), n_pe - b_pe, vecs[v].exp_pe);
      check($sformatf("v%0d_frame_err", v), n_fe - b_fe, vecs[v].exp_fe);
      check($sformatf("v%0d_break", v), n_bk - b_bk, vecs[v].exp_bk);
      check($sformatf("v%0d_overrun", v), n_ovr - b_ovr, 0);
    end

    // busy must have dropped by two cycles after the final stop sample
    prescale = 16'd1; data_bits = 4'd8; parity_mode = 2'b00; stop_bits = 1'b0;
    busy_after = 1'b1;
    send(9'h055, 8, 0, 0, 1, 1, 1, 8);
    wait_idle("busy_seq_idle");
    check("busy_after_stop", busy_after, 0);
    rx_q.delete();

    // long break: 12 bit times low
    b_x = n_xfer; b_fe = n_fe; b_bk = n_bk;
    rxd = 1'b0;
    repeat (96) @(negedge clk);
    check("break_busy_held", busy, 1);
    check("break_pulse", n_bk - b_bk, 1);
    check("break_no_frame", n_fe - b_fe, 0);
    check("break_no_xfer", n_xfer - b_x, 0);
    rxd = 1'b1;
    wait_idle("break_release_idle");

    // 2-cycle glitch on idle line
    b_x = n_xfer; b_pe = n_pe; b_fe = n_fe; b_bk = n_bk;
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy", busy, 0);
    check("glitch_no_xfer", n_xfer - b_x, 0);
    check("glitch_no_err", (n_pe - b_pe) + (n_fe - b_fe) + (n_bk - b_bk), 0);

`ifdef UART_RX_FIFO_EN
    m_axis.tready = 1'b0;
    b_x = n_xfer; b_ovr = n_ovr;
    for (int i = 1; i <= 4; i++) begin
      send(9'(i), 8, 0, 0, 1, 1, 1, 8);
      wait_idle($sformatf("fifo_fill%0d_idle", i));
    end
    check("fifo_no_ovr_at_4", n_ovr - b_ovr, 0);
    send(9'h005, 8, 0, 0, 1, 1, 1, 8);
    wait_idle("fifo_fill5_idle");
    check("fifo_ovr_at_5", n_ovr - b_ovr, 1);
    check("fifo_tvalid", m_axis.tvalid, 1);
    check("fifo_no_xfer", n_xfer - b_x, 0);
    rx_q.delete();
    m_axis.tready = 1'b1;
    repeat (10) @(negedge clk);
    check("fifo_drain_count", n_xfer - b_x, 4);
    for (int i = 0; i < 4; i++) begin
      got = (rx_q.size() > i) ? rx_q[i] : 'x;
      check($sformatf("fifo_order%0d", i), got, 9'(i + 1));
    end
    check("fifo_empty", m_axis.tvalid, 0);
    rx_q.delete();
`else
    m_axis.tready = 1'b0;
    b_x = n_xfer; b_ovr = n_ovr;
    send(9'h00A, 8, 0, 0, 1, 1, 1, 8);
    wait_idle("ovr_w1_idle");
    check("ovr_none_first", n_ovr - b_ovr, 0);
    check("ovr_hold_tdata", m_axis.tdata, 9'h00A);
    send(9'h00B, 8, 0, 0, 1, 1, 1, 8);
    wait_idle("ovr_w2_idle");
    check("ovr_pulse", n_ovr - b_ovr, 1);
    check("ovr_tvalid", m_axis.tvalid, 1);
    check("ovr_tdata", m_axis.tdata, 9'h00B);
    check("ovr_no_xfer", n_xfer - b_x, 0);
    rx_q.delete();
    m_axis.tready = 1'b1;
    repeat (3) @(negedge clk);
    check("ovr_drain_count", n_xfer - b_x, 1);
    got = (rx_q.size() > 0) ? rx_q[0] : 'x;
    check("ovr_drain_data", got, 9'h00B);
    check("ovr_tvalid_clear", m_axis.tvalid, 0);
    rx_q.delete();
`endif

    // reset in the middle of the data bits
    b_x = n_xfer; b_pe = n_pe; b_fe = n_fe; b_bk = n_bk;
    bit_time(1'b0, 8);
    bit_time(1'b1, 8);
    bit_time(1'b0, 4);
    check("mid_busy_before_rst", busy, 1);
    rst = 1'b1;
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_tvalid", m_axis.tvalid, 0);
    repeat (100) @(negedge clk);
    check("rst_mid_no_xfer", n_xfer - b_x, 0);
    check("rst_mid_no_pulse", (n_pe - b_pe) + (n_fe - b_fe) + (n_bk - b_bk), 0);
    check("rst_mid_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 Parameter DATA_WIDTH, default 9: maximum data bits per character; legal range 5..9.
REQ-002 Parameter FIFO_DEPTH, default 4: output FIFO entries, power of two, at least 2; used only when UART_RX_FIFO_EN is defined.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rxd  in  1  asynchronous serial input, idle high.
REQ-006 prescale  in  16  bit period = 8*prescale clk cycles; value 0 treated as 1.
REQ-007 data_bits  in  4  character length 5..DATA_WIDTH; out-of-range values clamp to DATA_WIDTH.
REQ-008 parity_mode  in  2  00 none, 01 even, 10 odd, 11 none.
REQ-009 stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
REQ-010 m_axis_tdata  out  DATA_WIDTH  received character, LSB-aligned, unused upper bits zero.
REQ-011 m_axis_tvalid  out  1 / m_axis_tready  in  1  AXI-Stream handshake; transfer when both high.
REQ-012 busy  out  1  high from start-bit detection until return to IDLE.
REQ-013 overrun_error, frame_error, parity_error, break_detect  out  1 each  single-cycle pulses.

Function
REQ-014 rxd shall pass a 2-flop synchronizer initialised to 1; all decisions use the synchronized value.
REQ-015 prescale, data_bits, parity_mode and stop_bits shall be captured on leaving IDLE and held for the whole character.
REQ-016 States: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
REQ-017 IDLE: on a synchronized low, go to START with a 4*prescale-1 cycle counter; busy asserts the next cycle.
REQ-018 Each bit value shall be the majority of three synchronized samples taken on the last three cycles of the bit interval.
REQ-019 START: majority high means a glitch; return to IDLE with no pulse. Majority low means go to DATA with an 8*prescale-1 counter.
REQ-020 DATA: shift data_bits samples in LSB first; then go to PARITY if parity is enabled, else STOP.
REQ-021 PARITY: parity_error is set when the data XOR parity bit is 1 for even, or 0 for odd.
REQ-022 STOP: sample one or two stop bits; any low stop bit is a frame error.
REQ-023 After the final stop sample: if data, parity and all stop samples are all 0, pulse break_detect only (no frame_error, no word) and go to BREAK_WAIT.
REQ-024 Otherwise, on a frame error pulse frame_error and discard the word. Frame error takes precedence over parity error.
REQ-025 Otherwise, on a parity error pulse parity_error and discard the word.
REQ-026 Otherwise, deliver the word; tvalid is high in the cycle after the final stop sample.
REQ-027 After REQ-024..026, go to IDLE.
REQ-028 BREAK_WAIT: stay until the synchronized rxd is high, then go to IDLE; no new start bit is detected before then.
REQ-029 busy shall be low in IDLE and high in every other state, including BREAK_WAIT.
REQ-030 The prescale counter shall be 19 bits wide and must not wrap for prescale = 16'hFFFF.

Reset
REQ-031 On reset: state IDLE, synchronizer 1, counters 0, busy 0, tvalid 0, tdata 0, all error pulses 0, FIFO empty.
REQ-032 Reset asserted mid-character shall abort the character with no pulse and no delivered word.

Configuration
REQ-033 Macro UART_RX_FIFO_EN defined: delivered words enter a FIFO_DEPTH FIFO that drives the m_axis outputs.
REQ-033a With the FIFO, tvalid = not empty; a push and pop in the same cycle are both honoured when full.
REQ-033b If a word is delivered while the FIFO is full and not popping, the word is dropped and overrun_error pulses.
REQ-034 Macro UART_RX_FIFO_EN undefined: a single output register is used.
REQ-034a Without the FIFO, a new word overwrites the register, tvalid stays high, and overrun_error pulses if tvalid was high and not handshaken in that cycle.

Verification
REQ-035 Setup prescale=1, 8N1, tready=1; send 0x55 -> exactly one transfer with tdata=0x55; busy low within 2 cycles after the stop sample; no error pulses.
REQ-036 Setup 7E1; send 0x41 with parity bit 0 -> transfer of 0x041. Repeat with parity bit 1 -> parity_error pulse and no transfer.
REQ-037 Setup 8N1; hold rxd low for 12 bit times -> one break_detect pulse, no frame_error, no transfer; busy low only after rxd returns high.
REQ-038 Setup 8N2; second stop bit low -> frame_error pulse and no transfer. A 2-cycle low glitch on idle rxd -> no word and no error.
REQ-039 Setup FIFO_EN, depth 4, tready=0; send 5 bytes 0x01..0x05 -> overrun_error on byte 5; then tready=1 -> 0x01..0x04 in order.
REQ-040 Setup no FIFO, tready=0; send 0x0A then 0x0B -> overrun_error pulse and tdata=0x0B. Reset mid-DATA -> idle state, no tvalid.
